// File: rtl/drop_controller_pkg.sv
// Shared game constants: board geometry, drop FSM encoding and the drop result payload.
package drop_controller_pkg;

  localparam int unsigned NUM_COLS = 7;
  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned ROW_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_WRITE    = 3'd2,
    S_RESP     = 3'd3,
    S_WAIT_LOW = 3'd4
  } state_e;

  typedef struct packed {
    logic             ok;
    logic [ROW_W-1:0] row;
  } drop_resp_t;

endpackage

// File: rtl/drop_controller_column_stack.sv
// One board column: thermometer occupancy, per-cell owner bits, full flag and next landing row.
module column_stack
  import drop_controller_pkg::*;
#(
  parameter int unsigned ROWS = NUM_ROWS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             insert,
  input  logic             player,
  output logic [ROWS-1:0]  onoff,
  output logic [ROWS-1:0]  owner,
  output logic             full_c,
  output logic [ROW_W-1:0] row_c
);

  // Owner bit of the new piece lands at the current fill count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      onoff <= '0;
      owner <= '0;
    end else if (clear) begin
      onoff <= '0;
      owner <= '0;
    end else if (insert && !onoff[ROWS-1]) begin
      onoff <= {onoff[ROWS-2:0], 1'b1};
      owner <= owner | (ROWS'(player) << row_c);
    end
  end

  assign full_c = onoff[ROWS-1];

  always_comb begin
    row_c = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_c = row_c + ROW_W'(onoff[i]);
    end
  end

endmodule

// File: rtl/drop_controller.sv
// Drop controller: request FSM, column select and registered response for a connect-four board.
module drop_controller #(
  parameter int unsigned NUM_COLS = drop_controller_pkg::NUM_COLS,
  parameter int unsigned NUM_ROWS = drop_controller_pkg::NUM_ROWS
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         drop_req,
  input  logic [2:0]                   drop_col,
  output logic                         drop_ack,
  output logic                         drop_ok,
  output logic [2:0]                   drop_row,
  output logic                         player,
  output logic [NUM_COLS*NUM_ROWS-1:0] col_onoff,
  output logic [NUM_COLS*NUM_ROWS-1:0] col_owner,
  output logic                         board_full
);

  import drop_controller_pkg::COL_W;
  import drop_controller_pkg::ROW_W;
  import drop_controller_pkg::state_e;
  import drop_controller_pkg::drop_resp_t;
  import drop_controller_pkg::S_IDLE;
  import drop_controller_pkg::S_CHECK;
  import drop_controller_pkg::S_WRITE;
  import drop_controller_pkg::S_RESP;
  import drop_controller_pkg::S_WAIT_LOW;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             reject_q, reject_d;
  drop_resp_t       res_q, res_d;
  logic             ack_d, ok_d, player_d;
  logic [ROW_W-1:0] row_d;
  logic             insert_c;

  logic             col_full [NUM_COLS];
  logic [ROW_W-1:0] col_row  [NUM_COLS];
  logic             sel_full_c;
  logic [ROW_W-1:0] sel_row_c;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    column_stack #(.ROWS(NUM_ROWS)) u_col (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear),
      .insert (insert_c && (col_q == COL_W'(c))),
      .player (player),
      .onoff  (col_onoff[c*NUM_ROWS +: NUM_ROWS]),
      .owner  (col_owner[c*NUM_ROWS +: NUM_ROWS]),
      .full_c (col_full[c]),
      .row_c  (col_row[c])
    );
  end

  // Column select by comparison so an out-of-range column reads as empty.
  always_comb begin
    sel_full_c = 1'b0;
    sel_row_c  = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_q == COL_W'(c)) begin
        sel_full_c = col_full[c];
        sel_row_c  = col_row[c];
      end
    end
  end

  assign board_full = &col_onoff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      reject_q <= 1'b0;
      res_q    <= '0;
      drop_ack <= 1'b0;
      drop_ok  <= 1'b0;
      drop_row <= '0;
      player   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      reject_q <= reject_d;
      res_q    <= res_d;
      drop_ack <= ack_d;
      drop_ok  <= ok_d;
      drop_row <= row_d;
      player   <= player_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    reject_d = reject_q;
    res_d    = res_q;
    ack_d    = 1'b0;
    ok_d     = drop_ok;
    row_d    = drop_row;
    player_d = player;
    insert_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (drop_req) begin
          col_d   = drop_col;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        reject_d = (32'(col_q) >= NUM_COLS) || sel_full_c;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        insert_c  = !reject_q;
        res_d.ok  = !reject_q;
        res_d.row = reject_q ? '0 : sel_row_c;
        state_d   = S_RESP;
      end
      S_RESP: begin
        ack_d    = 1'b1;
        ok_d     = res_q.ok;
        row_d    = res_q.row;
        player_d = player ^ res_q.ok;
        state_d  = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!drop_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New game overrides any in-flight drop.
    if (clear) begin
      state_d  = S_IDLE;
      insert_c = 1'b0;
      ack_d    = 1'b0;
      ok_d     = 1'b0;
      row_d    = '0;
      player_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller: vector table of drops plus multi-cycle corner sequences.
module tb_drop_controller;

  localparam int W = 42;

  logic         clk = 1'b0;
  logic         resetn;
  logic         clear;
  logic         drop_req;
  logic [2:0]   drop_col;
  logic         drop_ack;
  logic         drop_ok;
  logic [2:0]   drop_row;
  logic         player;
  logic [W-1:0] col_onoff;
  logic [W-1:0] col_owner;
  logic         board_full;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] col;
    logic       ok;
    logic [2:0] row;
    logic       ply;
  } vec_t;

  drop_controller dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .drop_req   (drop_req),
    .drop_col   (drop_col),
    .drop_ack   (drop_ack),
    .drop_ok    (drop_ok),
    .drop_row   (drop_row),
    .player     (player),
    .col_onoff  (col_onoff),
    .col_owner  (col_owner),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One complete drop: request at a falling edge, wait for ack, check response, release.
  task automatic do_drop(input logic [2:0] col, input logic eok, input logic [2:0] erow,
                         input logic eply, input string name);
    int cyc;
    drop_col = col;
    drop_req = 1'b1;
    cyc = 0;
    while (!drop_ack && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd4);
    check({name, "_ok"}, 64'(drop_ok), 64'(eok));
    check({name, "_row"}, 64'(drop_row), 64'(erow));
    check({name, "_player"}, 64'(player), 64'(eply));
    drop_req = 1'b0;
    drop_col = 3'd6;
    @(negedge clk);
    check({name, "_ack_pulse"}, 64'(drop_ack), 64'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    logic exp_ply;
    int   acks;

    vecs[0]  = '{3'd0, 1'b1, 3'd0, 1'b1};
    vecs[1]  = '{3'd0, 1'b1, 3'd1, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 3'd2, 1'b1};
    vecs[3]  = '{3'd0, 1'b1, 3'd3, 1'b0};
    vecs[4]  = '{3'd0, 1'b1, 3'd4, 1'b1};
    vecs[5]  = '{3'd0, 1'b1, 3'd5, 1'b0};
    vecs[6]  = '{3'd0, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{3'd7, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{3'd1, 1'b1, 3'd0, 1'b1};
    vecs[9]  = '{3'd7, 1'b0, 3'd0, 1'b1};
    vecs[10] = '{3'd1, 1'b1, 3'd1, 1'b0};

    resetn   = 1'b0;
    clear    = 1'b0;
    drop_req = 1'b0;
    drop_col = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_onoff", 64'(col_onoff), 64'd0);
    check("rst_owner", 64'(col_owner), 64'd0);
    check("rst_ack", 64'(drop_ack), 64'd0);
    check("rst_ok", 64'(drop_ok), 64'd0);
    check("rst_row", 64'(drop_row), 64'd0);
    check("rst_player", 64'(player), 64'd0);
    check("rst_full", 64'(board_full), 64'd0);
    resetn = 1'b1;

    do_drop(3'd3, 1'b1, 3'd0, 1'b1, "first_col3");
    check("first_onoff", 64'(col_onoff), 64'h1 << 18);
    check("first_owner", 64'(col_owner), 64'd0);

    pulse_clear();
    check("clr1_player", 64'(player), 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_drop(vecs[i].col, vecs[i].ok, vecs[i].row, vecs[i].ply, $sformatf("vec%0d", i));
    end
    check("vec_onoff", 64'(col_onoff), 64'h0FF);
    check("vec_owner", 64'(col_owner), 64'h0AA);

    // Held request: a single drop regardless of how long drop_req stays high.
    pulse_clear();
    drop_col = 3'd2;
    drop_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drop_ack) acks++;
    end
    drop_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_acks", 64'(acks), 64'd1);
    check("held_onoff", 64'(col_onoff), 64'h1 << 12);
    check("held_player", 64'(player), 64'd1);

    // Fill the whole board; players alternate from 0.
    pulse_clear();
    exp_ply = 1'b0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        exp_ply = ~exp_ply;
        do_drop(3'(c), 1'b1, 3'(r), exp_ply, $sformatf("fill_c%0d_r%0d", c, r));
        if (c == 6 && r == 4) check("fill_not_full", 64'(board_full), 64'd0);
      end
    end
    check("fill_full", 64'(board_full), 64'd1);
    check("fill_onoff", 64'(col_onoff), {22'd0, 42'h3FF_FFFF_FFFF});
    pulse_clear();
    check("clr_onoff", 64'(col_onoff), 64'd0);
    check("clr_owner", 64'(col_owner), 64'd0);
    check("clr_full", 64'(board_full), 64'd0);
    check("clr_ok", 64'(drop_ok), 64'd0);
    check("clr_row", 64'(drop_row), 64'd0);
    check("clr_ack", 64'(drop_ack), 64'd0);
    check("clr_player", 64'(player), 64'd0);

    // Async reset while the third drop into column 5 sits in WRITE.
    do_drop(3'd5, 1'b1, 3'd0, 1'b1, "pre_rst_a");
    do_drop(3'd5, 1'b1, 3'd1, 1'b0, "pre_rst_b");
    drop_col = 3'd5;
    drop_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("wrst_onoff", 64'(col_onoff), 64'd0);
    check("wrst_owner", 64'(col_owner), 64'd0);
    check("wrst_ok", 64'(drop_ok), 64'd0);
    check("wrst_row", 64'(drop_row), 64'd0);
    check("wrst_player", 64'(player), 64'd0);
    check("wrst_ack", 64'(drop_ack), 64'd0);
    @(negedge clk);
    drop_req = 1'b0;
    resetn = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (drop_ack) acks++;
    end
    check("wrst_no_ack", 64'(acks), 64'd0);
    check("wrst_board", 64'(col_onoff), 64'd0);

    // Clear while the request sits in CHECK aborts it.
    do_drop(3'd4, 1'b1, 3'd0, 1'b1, "pre_clr");
    drop_col = 3'd4;
    drop_req = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drop_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (drop_ack) acks++;
      @(negedge clk);
    end
    check("cclr_no_ack", 64'(acks), 64'd0);
    check("cclr_board", 64'(col_onoff), 64'd0);
    check("cclr_owner", 64'(col_owner), 64'd0);
    check("cclr_player", 64'(player), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drop_controller.md
DROP_CONTROLLER -- requirements
Module: drop_controller

Interface
REQ-001 The parameter NUM_COLS SHALL default to 7 and give the number of board columns.
REQ-002 The parameter NUM_ROWS SHALL default to 6 and give the number of rows per column.
REQ-003 The port clk SHALL be an input of width 1 and be the single system clock; all state changes on its rising edge.
REQ-004 The port resetn SHALL be an input of width 1 and be an asynchronous, active-low reset.
REQ-005 The port clear SHALL be an input of width 1 and act as a synchronous new-game request.
REQ-006 The port drop_req SHALL be an input of width 1 and be a level request to drop a piece.
REQ-007 The port drop_col SHALL be an input of width 3 and give the target column; it is valid while drop_req is high.
REQ-008 The port drop_ack SHALL be an output of width 1 and be a one-cycle completion pulse.
REQ-009 The port drop_ok SHALL be an output of width 1 and is valid with drop_ack: 1 = piece placed, 0 = rejected.
REQ-010 The port drop_row SHALL be an output of width 3 and is valid with drop_ack: the landing row index.
REQ-011 The port player SHALL be an output of width 1 and give the player to move (0 = first player).
REQ-012 The port col_onoff SHALL be an output of width NUM_COLS*NUM_ROWS and carry the per-column thermometer occupancy; column c occupies bits [c*6+5:c*6].
REQ-013 The port col_owner SHALL be an output of width NUM_COLS*NUM_ROWS and carry the per-cell owner bit, using the same layout as col_onoff.
REQ-014 The port board_full SHALL be an output of width 1 and be high when every cell is occupied.

Function
REQ-015 Each column occupancy SHALL be thermometer coded: bit 0 is filled first, legal values are 000000, 000001, 000011, ... 111111.
REQ-016 The FSM SHALL have the states IDLE, CHECK, WRITE, RESP and WAIT_LOW.
REQ-017 In IDLE, drop_req=1 SHALL latch drop_col and go to CHECK; otherwise the FSM stays in IDLE.
REQ-018 CHECK SHALL set reject if the latched column is >= NUM_COLS or the column's bit 5 is set, then go to WRITE.
REQ-019 For an accepted drop, WRITE SHALL set new onoff = {old[4:0],1'b1} and owner[k] = player, where k = the newly set bit.
REQ-020 WRITE SHALL set drop_row = number of set bits after insertion minus 1, giving a range of 0..5 (000001->0, 111111->5).
REQ-021 For a rejected drop, WRITE SHALL leave the board, drop_row (forced to 0) and player unchanged.
REQ-022 RESP SHALL assert drop_ack for exactly one cycle and toggle player only if drop_ok=1.
REQ-023 From RESP the FSM SHALL go to WAIT_LOW and return to IDLE only when drop_req=0, so a held request produces exactly one drop.
REQ-024 Latency SHALL be fixed: a request sampled in IDLE at edge N produces drop_ack high during the cycle after edge N+3.
REQ-025 drop_ok and drop_row SHALL hold their values until the next RESP.
REQ-026 board_full SHALL be combinational: the AND of all col_onoff bits.
REQ-027 Owner bits of unoccupied cells SHALL be 0.
REQ-028 clear=1 SHALL take priority over everything in any state: the next edge zeroes col_onoff, col_owner, drop_ok, drop_row and drop_ack, sets player=0 and sets state=IDLE.
REQ-029 A clear that coincides with a drop in progress SHALL abort the drop with no ack issued.
REQ-030 drop_col changes after the latch SHALL be ignored.

Reset
REQ-031 resetn=0 SHALL asynchronously force state=IDLE, col_onoff=0, col_owner=0, player=0, drop_ack=0, drop_ok=0 and drop_row=0.
REQ-032 Reset release SHALL take effect at the first clk edge with resetn=1; a request already high at release is serviced normally.

Structure
REQ-033 NUM_COLS, NUM_ROWS and the FSM state encodings SHALL live in the shared game constants package/include used by the board and VGA blocks.
REQ-034 One sub-module, column_stack, SHALL hold a column's 6-bit onoff and owner registers, insert enable, full flag and row output; it is instantiated NUM_COLS times.
REQ-035 The top level SHALL contain only the FSM, the column select logic and the output registers.

Verification
REQ-036 The bench SHALL cover: reset, then drop_req=1 with col=3 -> drop_ack 4 cycles later, ok=1, row=0, col_onoff[23:18]=000001, owner bit 18=0, player=1.
REQ-037 The bench SHALL cover: six accepted drops into col 0 with alternating players -> rows 0..5, col_onoff[5:0]=111111, col_owner[5:0]=101010; a seventh drop -> ok=0, row=0, player unchanged.
REQ-038 The bench SHALL cover: drop_col=7 -> ok=0, board unchanged, player unchanged.
REQ-039 The bench SHALL cover: drop_req held high for 20 cycles -> exactly one drop_ack and a single bit added.
REQ-040 The bench SHALL cover: fill all 42 cells -> board_full=1 after the 42nd ack; then clear=1 for one cycle -> all outputs 0 and player=0.
REQ-041 The bench SHALL cover: resetn asserted during WRITE -> outputs 0 immediately with no drop_ack; clear asserted during CHECK -> no ack and board zero.
